// File: rtl/inter_pkg.sv
// inter_pkg: shared FSM encoding, default sizes and request-word field extractors
package inter_pkg;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam int N_MST_DEF  = 2;
    localparam int N_SLV_DEF  = 2;
    localparam int ADDR_W_DEF = 3;
    localparam int VAL_W_DEF  = 3;

    function automatic logic [31:0] field_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] get_sel(input logic [31:0] word, input int slv_w,
                                            input int addr_w, input int val_w);
        return (word >> (addr_w + val_w)) & field_mask(slv_w);
    endfunction

    function automatic logic [31:0] get_addr(input logic [31:0] word, input int addr_w,
                                             input int val_w);
        return (word >> val_w) & field_mask(addr_w);
    endfunction

    function automatic logic [31:0] get_val(input logic [31:0] word, input int val_w);
        return word & field_mask(val_w);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr wins
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int  idx;
    logic found;

    // scan requesters starting at ptr, wrapping, and grant the first one seen
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inter_multi.sv
// inter_multi: multi-master to multi-slave interconnect with one shared round-robin bus
module inter_multi
    import inter_pkg::*;
#(
    parameter int N_MST  = N_MST_DEF,
    parameter int N_SLV  = N_SLV_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int VAL_W  = VAL_W_DEF,
    localparam int SLV_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1,
    localparam int DATA_W = SLV_W + ADDR_W + VAL_W,
    localparam int GW     = $clog2(N_MST)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_MST-1:0]         in_valid,
    input  logic [N_MST*DATA_W-1:0]  data_in,
    output logic [N_MST-1:0]         in_ready,
    output logic [N_SLV-1:0]         valid_slave,
    input  logic [N_SLV-1:0]         ready_slave,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [VAL_W-1:0]         value_out,
    output logic [N_MST-1:0]         handshake_master,
    output logic [N_MST-1:0]         err_master,
    output logic [GW-1:0]            grant_id
);

    state_t            state;
    logic [N_MST-1:0]  pend, bad, gnt;
    logic [DATA_W-1:0] bufs [N_MST];
    logic [GW-1:0]     rr_ptr, win;
    logic [DATA_W-1:0] wd;
    logic [31:0]       w_sel, w_addr, w_val, nxt_ptr;
    logic              done;

    assign in_ready = ~pend;
    assign done     = (state == SEND) && |(ready_slave & valid_slave);

    rr_arbiter #(.N(N_MST), .PW(GW)) u_arb (
        .req(pend),
        .ptr(rr_ptr),
        .gnt(gnt)
    );

    // flag incoming words whose slave select addresses no existing slave
    always_comb begin
        bad = '0;
        for (int i = 0; i < N_MST; i++)
            bad[i] = get_sel(32'(data_in[i*DATA_W +: DATA_W]), SLV_W, ADDR_W, VAL_W) >= 32'(N_SLV);
    end

    // encode the one-hot grant and split the winning buffer into bus fields
    always_comb begin
        win = '0;
        for (int i = 0; i < N_MST; i++)
            if (gnt[i]) win = GW'(i);
        wd      = bufs[win];
        w_sel   = get_sel(32'(wd), SLV_W, ADDR_W, VAL_W);
        w_addr  = get_addr(32'(wd), ADDR_W, VAL_W);
        w_val   = get_val(32'(wd), VAL_W);
        nxt_ptr = (32'(grant_id) + 32'd1) % 32'(N_MST);
    end

    // per-master request buffers: capture when empty, free on completion, flag bad selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            err_master <= '0;
            for (int i = 0; i < N_MST; i++) bufs[i] <= '0;
        end else begin
            for (int i = 0; i < N_MST; i++) begin
                err_master[i] <= in_valid[i] && !pend[i] && bad[i];
                if (in_valid[i] && !pend[i] && !bad[i]) begin
                    pend[i] <= 1'b1;
                    bufs[i] <= data_in[i*DATA_W +: DATA_W];
                end
                if (done && grant_id == GW'(i)) pend[i] <= 1'b0;
            end
        end
    end

    // bus FSM: launch the arbitration winner from IDLE, hold it in SEND until its slave accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            valid_slave      <= '0;
            addr_out         <= '0;
            value_out        <= '0;
            grant_id         <= '0;
            handshake_master <= '0;
        end else begin
            handshake_master <= '0;
            if (state == IDLE) begin
                if (|pend) begin
                    state       <= SEND;
                    valid_slave <= N_SLV'(32'd1 << w_sel);
                    addr_out    <= w_addr[ADDR_W-1:0];
                    value_out   <= w_val[VAL_W-1:0];
                    grant_id    <= win;
                end
            end else if (done) begin
                state            <= IDLE;
                valid_slave      <= '0;
                addr_out         <= '0;
                value_out        <= '0;
                handshake_master <= N_MST'(1) << grant_id;
                rr_ptr           <= nxt_ptr[GW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_inter_multi.sv
// tb_inter_multi: directed checks of capture, arbitration, stall, bad select, reset and scaling
module tb_inter_multi;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: defaults (2 masters, 2 slaves, DATA_W 7)
    logic [1:0]  iv_a, ir_a, vs_a, rs_a, hs_a, er_a;
    logic [13:0] di_a;
    logic [2:0]  ao_a, vo_a;
    logic [0:0]  gid_a;

    // DUT B: 4 masters, 3 slaves (DATA_W 8)
    logic [3:0]  iv_b, ir_b, hs_b, er_b;
    logic [31:0] di_b;
    logic [2:0]  vs_b, rs_b, ao_b, vo_b;
    logic [1:0]  gid_b;

    // DUT C: 4 masters, 4 slaves (DATA_W 8)
    logic [3:0]  iv_c, ir_c, hs_c, er_c, vs_c, rs_c;
    logic [31:0] di_c;
    logic [2:0]  ao_c, vo_c;
    logic [1:0]  gid_c;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_tot;

    inter_multi u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .data_in(di_a), .in_ready(ir_a),
        .valid_slave(vs_a), .ready_slave(rs_a), .addr_out(ao_a), .value_out(vo_a),
        .handshake_master(hs_a), .err_master(er_a), .grant_id(gid_a)
    );

    inter_multi #(.N_MST(4), .N_SLV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .data_in(di_b), .in_ready(ir_b),
        .valid_slave(vs_b), .ready_slave(rs_b), .addr_out(ao_b), .value_out(vo_b),
        .handshake_master(hs_b), .err_master(er_b), .grant_id(gid_b)
    );

    inter_multi #(.N_MST(4), .N_SLV(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .data_in(di_c), .in_ready(ir_c),
        .valid_slave(vs_c), .ready_slave(rs_c), .addr_out(ao_c), .value_out(vo_c),
        .handshake_master(hs_c), .err_master(er_c), .grant_id(gid_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // m0 -> slave0 addr1 val1, m1 -> slave1 addr2 val2; a wins first, then b
    task automatic contend(input int a, input int b);
        di_a = {7'b1_010_010, 7'b0_001_001};
        iv_a = 2'b11;
        rs_a = 2'b11;
        step();
        iv_a = 2'b00;
        chk("cont_cap_ready", ir_a, 2'b00);
        step();
        chk("cont_grant1", gid_a, a);
        chk("cont_valid1", vs_a, 32'd1 << a);
        chk("cont_bus1", {ao_a, vo_a}, {3'(a + 1), 3'(a + 1)});
        step();
        chk("cont_hs1", hs_a, 32'd1 << a);
        chk("cont_idle_valid", vs_a, 0);
        chk("cont_ready_mid", ir_a, 32'd1 << a);
        step();
        chk("cont_grant2", gid_a, b);
        chk("cont_valid2", vs_a, 32'd1 << b);
        chk("cont_hs_gap", hs_a, 0);
        step();
        chk("cont_hs2", hs_a, 32'd1 << b);
        chk("cont_ready_end", ir_a, 2'b11);
        step();
        chk("cont_hs_clear", hs_a, 0);
        rs_a = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        iv_a = '0; di_a = '0; rs_a = '0;
        iv_b = '0; di_b = '0; rs_b = '0;
        iv_c = '0; di_c = '0; rs_c = '0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_a", {vs_a, ao_a, vo_a, gid_a, hs_a, er_a, ir_a},
            {2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b00, 2'b11});
        chk("rst_b", {vs_b, ir_b, er_b}, {3'b000, 4'b1111, 4'b0000});
        chk("rst_c", {vs_c, ir_c, hs_c}, {4'b0000, 4'b1111, 4'b0000});

        // single transfer: slave1 addr5 val3 from master0
        di_a[6:0] = 7'b1_101_011;
        iv_a = 2'b01;
        step();
        iv_a = 2'b00;
        chk("single_cap_ready", ir_a, 2'b10);
        chk("single_cap_valid", vs_a, 2'b00);
        step();
        chk("single_valid", vs_a, 2'b10);
        chk("single_addr", ao_a, 3'd5);
        chk("single_value", vo_a, 3'd3);
        chk("single_grant", gid_a, 1'b0);
        rs_a = 2'b10;
        step();
        rs_a = 2'b00;
        chk("single_hs", hs_a, 2'b01);
        chk("single_ready_back", ir_a, 2'b11);
        chk("single_idle_bus", {vs_a, ao_a, vo_a}, 8'd0);
        step();
        chk("single_hs_once", hs_a, 2'b00);

        // pointer sits at 1 after master0 finished, so master1 goes first
        contend(1, 0);
        pulse_reset();
        step();
        contend(0, 1);

        // stall: master0 held in SEND, master1 pending and re-asserting new data
        pulse_reset();
        step();
        di_a = {7'b0_010_100, 7'b1_101_011};
        iv_a = 2'b11;
        rs_a = 2'b01;
        step();
        di_a[13:7] = 7'b1_111_111;
        iv_a = 2'b10;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("stall_hold", {vs_a, ao_a, vo_a, ir_a, er_a, hs_a},
                {2'b10, 3'd5, 3'd3, 2'b00, 2'b00, 2'b00});
            step();
        end
        iv_a = 2'b00;
        rs_a = 2'b10;
        step();
        chk("stall_release_hs", hs_a, 2'b01);
        chk("stall_release_ready", ir_a, 2'b01);
        rs_a = 2'b01;
        step();
        chk("stall_m1_grant", gid_a, 1'b1);
        chk("stall_m1_bus", {vs_a, ao_a, vo_a}, {2'b01, 3'd2, 3'd4});
        step();
        chk("stall_m1_hs", hs_a, 2'b10);
        rs_a = 2'b00;
        step();

        // reset while master1 is on the bus
        di_a[13:7] = 7'b0_010_100;
        iv_a = 2'b10;
        step();
        iv_a = 2'b00;
        step();
        chk("pre_rst_send", {vs_a, gid_a}, {2'b01, 1'b1});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {vs_a, ao_a, vo_a, gid_a, hs_a, er_a, ir_a},
            {2'b00, 3'd0, 3'd0, 1'b0, 2'b00, 2'b00, 2'b11});
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", vs_a, 2'b00);
        contend(0, 1);

        // bad slave select on 3-slave instance
        di_b[23:16] = 8'b11_000_000;
        iv_b = 4'b0100;
        step();
        iv_b = 4'b0000;
        chk("bad_err", er_b, 4'b0100);
        chk("bad_ready", ir_b, 4'b1111);
        chk("bad_no_valid", vs_b, 3'b000);
        step();
        chk("bad_err_once", er_b, 4'b0000);
        chk("bad_no_valid2", vs_b, 3'b000);
        step();
        chk("bad_no_valid3", {vs_b, hs_b}, 7'd0);

        // four masters, four slaves, all request at once
        rs_c = 4'hf;
        for (int k = 0; k < 4; k++) di_c[k*8 +: 8] = {2'(k), 3'(k + 1), 3'(7 - k)};
        iv_c = 4'hf;
        step();
        iv_c = 4'h0;
        hs_tot = $countones(hs_c);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("scale_grant", gid_c, k);
            chk("scale_valid", vs_c, 32'd1 << k);
            chk("scale_bus", {ao_c, vo_c}, {3'(k + 1), 3'(7 - k)});
            hs_tot += $countones(hs_c);
            step();
            chk("scale_hs", hs_c, 32'd1 << k);
            hs_tot += $countones(hs_c);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            hs_tot += $countones(hs_c);
        end
        chk("scale_hs_total", hs_tot, 4);
        chk("scale_end", {vs_c, ir_c}, {4'b0000, 4'b1111});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
